// File: rtl/bus_arbiter_2x32_if.sv
// Bus bundle for the two-master / one-slave 32-bit arbiter.
// The slave modport is the arbiter's view, and the master modport is the requesters' and bridge model's view.
interface bus_arbiter_2x32_if;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_wr_en;
  logic [3:0]  a_bytesel;
  logic [31:0] a_rdata;
  logic        a_compl;
  logic        a_err;

  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_wr_en;
  logic [3:0]  b_bytesel;
  logic [31:0] b_rdata;
  logic        b_compl;
  logic        b_err;

  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_wr_en;
  logic [3:0]  m_bytesel;
  logic [31:0] m_rdata;
  logic        m_compl;

  // Handshake: a master requests by holding a nonzero bytesel, and it keeps addr, wdata and wr_en stable
  // until its one-cycle compl strobe. On the slave side, one m_compl pulse ends the granted transfer.
  modport slave (
    input  a_addr, a_wdata, a_wr_en, a_bytesel,
    input  b_addr, b_wdata, b_wr_en, b_bytesel,
    output a_rdata, a_compl, a_err,
    output b_rdata, b_compl, b_err,
    output m_addr, m_wdata, m_wr_en, m_bytesel,
    input  m_rdata, m_compl
  );

  modport master (
    output a_addr, a_wdata, a_wr_en, a_bytesel,
    output b_addr, b_wdata, b_wr_en, b_bytesel,
    input  a_rdata, a_compl, a_err,
    input  b_rdata, b_compl, b_err,
    input  m_addr, m_wdata, m_wr_en, m_bytesel,
    output m_rdata, m_compl
  );
endinterface

// File: rtl/bus_arbiter_2x32.sv
// Round-robin arbiter that lets two 32-bit masters share one bridge_32_16 host port.
// A timeout ends a stalled grant and reports it through x_err.
module bus_arbiter_2x32 #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_arbiter_2x32_if.slave    bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = TIMEOUT_CYCLES - 8'd1;

  state_t     state;
  logic       last_grant_b;
  logic [7:0] tcnt;
  logic       req_a;
  logic       req_b;
  logic       timeout_hit;

  // A master whose compl strobe is high this cycle is masked, so it cannot be granted again at once.
  assign req_a = (bus.a_bytesel != 4'h0) && !bus.a_compl;
  assign req_b = (bus.b_bytesel != 4'h0) && !bus.b_compl;

  assign timeout_hit = (TIMEOUT_CYCLES != 8'd0) && (tcnt == TO_LAST);

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_b <= 1'b1;
      tcnt         <= 8'd0;
      bus.a_rdata  <= 32'h0;
      bus.a_compl  <= 1'b0;
      bus.a_err    <= 1'b0;
      bus.b_rdata  <= 32'h0;
      bus.b_compl  <= 1'b0;
      bus.b_err    <= 1'b0;
    end else begin
      bus.a_compl <= 1'b0;
      bus.a_err   <= 1'b0;
      bus.b_compl <= 1'b0;
      bus.b_err   <= 1'b0;
      case (state)
        IDLE: begin
          // On a tie, the master that was not granted last wins.
          if (req_a && (!req_b || last_grant_b)) begin
            state        <= GRANT_A;
            last_grant_b <= 1'b0;
            tcnt         <= 8'd0;
          end else if (req_b) begin
            state        <= GRANT_B;
            last_grant_b <= 1'b1;
            tcnt         <= 8'd0;
          end
        end
        GRANT_A: begin
          if (bus.m_compl) begin
            state       <= IDLE;
            bus.a_rdata <= bus.m_rdata;
            bus.a_compl <= 1'b1;
            bus.a_err   <= 1'b0;
          end else if (timeout_hit) begin
            state       <= IDLE;
            bus.a_rdata <= 32'h0;
            bus.a_compl <= 1'b1;
            bus.a_err   <= 1'b1;
          end else if (tcnt != 8'hff) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        GRANT_B: begin
          if (bus.m_compl) begin
            state       <= IDLE;
            bus.b_rdata <= bus.m_rdata;
            bus.b_compl <= 1'b1;
            bus.b_err   <= 1'b0;
          end else if (timeout_hit) begin
            state       <= IDLE;
            bus.b_rdata <= 32'h0;
            bus.b_compl <= 1'b1;
            bus.b_err   <= 1'b1;
          end else if (tcnt != 8'hff) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The slave port follows the granted master combinationally, so m_bytesel drops as soon as reset is asserted.
  always_comb begin
    bus.m_addr    = 32'h0;
    bus.m_wdata   = 32'h0;
    bus.m_wr_en   = 1'b0;
    bus.m_bytesel = 4'h0;
    case (state)
      GRANT_A: begin
        bus.m_addr    = bus.a_addr;
        bus.m_wdata   = bus.a_wdata;
        bus.m_wr_en   = bus.a_wr_en;
        bus.m_bytesel = bus.a_bytesel;
      end
      GRANT_B: begin
        bus.m_addr    = bus.b_addr;
        bus.m_wdata   = bus.b_wdata;
        bus.m_wr_en   = bus.b_wr_en;
        bus.m_bytesel = bus.b_bytesel;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_2x32.sv
// Directed bench for bus_arbiter_2x32: one instance with the default timeout and one with TIMEOUT_CYCLES=4.
module tb_bus_arbiter_2x32;
  logic clk;
  logic rst_n;
  logic [1:0] dbg_s;
  logic [1:0] dbg_s_to;
  int n_cmp;
  int n_bad;

  bus_arbiter_2x32_if bus();
  bus_arbiter_2x32_if bus_to();

  bus_arbiter_2x32 dut (.clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_s));
  bus_arbiter_2x32 #(.TIMEOUT_CYCLES(8'd4)) dut_to (.clk(clk), .rst_n(rst_n), .bus(bus_to), .dbg_state(dbg_s_to));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.a_addr = 32'h0; bus.a_wdata = 32'h0; bus.a_wr_en = 1'b0; bus.a_bytesel = 4'h0;
    bus.b_addr = 32'h0; bus.b_wdata = 32'h0; bus.b_wr_en = 1'b0; bus.b_bytesel = 4'h0;
    bus.m_rdata = 32'h0; bus.m_compl = 1'b0;
    bus_to.a_addr = 32'h0; bus_to.a_wdata = 32'h0; bus_to.a_wr_en = 1'b0; bus_to.a_bytesel = 4'h0;
    bus_to.b_addr = 32'h0; bus_to.b_wdata = 32'h0; bus_to.b_wr_en = 1'b0; bus_to.b_bytesel = 4'h0;
    bus_to.m_rdata = 32'h0; bus_to.m_compl = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (dbg_s !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dbg_s); end
    n_cmp++; if ({bus.a_compl, bus.b_compl, bus.a_err, bus.b_err} !== 4'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", {bus.a_compl, bus.b_compl, bus.a_err, bus.b_err}); end
    n_cmp++; if (bus.a_rdata !== 32'h0 || bus.b_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", bus.a_rdata, bus.b_rdata); end
    n_cmp++; if (bus.m_bytesel !== 4'h0) begin n_bad++; $display("FAIL rst_m_bytesel: got %h want 0", bus.m_bytesel); end
    n_cmp++; if (dbg_s_to !== 2'd0 || bus_to.a_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_to: got %0d/%h want 0/0", dbg_s_to, bus_to.a_rdata); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (dbg_s !== 2'd0) begin n_bad++; $display("FAIL rst_idle_after: got %0d want 0", dbg_s); end
  endtask

  task automatic test_single_read();
    bus.a_addr = 32'h8000bee0; bus.a_wr_en = 1'b0; bus.a_bytesel = 4'hf;
    tick();
    n_cmp++; if (dbg_s !== 2'd1) begin n_bad++; $display("FAIL rd_grant: got %0d want 1", dbg_s); end
    n_cmp++; if (bus.m_bytesel !== 4'hf || bus.m_addr !== 32'h8000bee0 || bus.m_wr_en !== 1'b0) begin n_bad++; $display("FAIL rd_m_bus: got %h %h %b want f 8000bee0 0", bus.m_bytesel, bus.m_addr, bus.m_wr_en); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus.a_compl !== 1'b0) begin n_bad++; $display("FAIL rd_early_compl: got %b want 0", bus.a_compl); end
    end
    bus.m_compl = 1'b1; bus.m_rdata = 32'h01020101;
    tick();
    bus.m_compl = 1'b0; bus.m_rdata = 32'h0;
    n_cmp++; if (bus.a_compl !== 1'b1 || bus.a_err !== 1'b0 || bus.b_compl !== 1'b0) begin n_bad++; $display("FAIL rd_compl: got a_compl=%b a_err=%b b_compl=%b want 1 0 0", bus.a_compl, bus.a_err, bus.b_compl); end
    n_cmp++; if (bus.a_rdata !== 32'h01020101) begin n_bad++; $display("FAIL rd_rdata: got %h want 01020101", bus.a_rdata); end
    n_cmp++; if (dbg_s !== 2'd0 || bus.m_bytesel !== 4'h0) begin n_bad++; $display("FAIL rd_back_idle: got %0d %h want 0 0", dbg_s, bus.m_bytesel); end
    bus.a_bytesel = 4'h0;
    tick();
    n_cmp++; if (bus.a_compl !== 1'b0 || bus.a_rdata !== 32'h01020101) begin n_bad++; $display("FAIL rd_hold: got %b %h want 0 01020101", bus.a_compl, bus.a_rdata); end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    bus.a_addr = 32'h100; bus.a_bytesel = 4'hf; bus.b_addr = 32'h200; bus.b_bytesel = 4'hf;
    tick();
    n_cmp++; if (dbg_s !== 2'd1 || bus.m_addr !== 32'h100) begin n_bad++; $display("FAIL rr_first_a: got %0d %h want 1 100", dbg_s, bus.m_addr); end
    bus.m_compl = 1'b1; bus.m_rdata = 32'haaaa0001;
    tick();
    bus.m_compl = 1'b0;
    n_cmp++; if (bus.a_compl !== 1'b1 || bus.b_compl !== 1'b0 || bus.a_rdata !== 32'haaaa0001) begin n_bad++; $display("FAIL rr_a_done: got %b %b %h want 1 0 aaaa0001", bus.a_compl, bus.b_compl, bus.a_rdata); end
    bus.a_bytesel = 4'h0;
    tick();
    n_cmp++; if (dbg_s !== 2'd2 || bus.m_addr !== 32'h200) begin n_bad++; $display("FAIL rr_then_b: got %0d %h want 2 200", dbg_s, bus.m_addr); end
    bus.m_compl = 1'b1; bus.m_rdata = 32'hbbbb0002;
    tick();
    bus.m_compl = 1'b0;
    n_cmp++; if (bus.b_compl !== 1'b1 || bus.a_compl !== 1'b0 || bus.b_rdata !== 32'hbbbb0002) begin n_bad++; $display("FAIL rr_b_done: got %b %b %h want 1 0 bbbb0002", bus.b_compl, bus.a_compl, bus.b_rdata); end
    bus.b_bytesel = 4'h0;
    tick();
    bus.a_bytesel = 4'hf; bus.b_bytesel = 4'hf;
    tick();
    n_cmp++; if (dbg_s !== 2'd1) begin n_bad++; $display("FAIL rr_alternate_a: got %0d want 1", dbg_s); end
    bus.m_compl = 1'b1; bus.m_rdata = 32'h3;
    tick();
    bus.m_compl = 1'b0; bus.a_bytesel = 4'h0; bus.b_bytesel = 4'h0;
    tick();
    n_cmp++; if (dbg_s !== 2'd0 || bus.a_rdata !== 32'h3) begin n_bad++; $display("FAIL rr_end_idle: got %0d %h want 0 3", dbg_s, bus.a_rdata); end
  endtask

  task automatic test_back_to_back();
    bus.b_addr = 32'h3000; bus.b_wdata = 32'hdeadbeef; bus.b_wr_en = 1'b1; bus.b_bytesel = 4'h3;
    tick();
    n_cmp++; if (dbg_s !== 2'd2 || bus.m_wdata !== 32'hdeadbeef || bus.m_wr_en !== 1'b1 || bus.m_bytesel !== 4'h3) begin n_bad++; $display("FAIL b2b_b_grant: got %0d %h %b %h want 2 deadbeef 1 3", dbg_s, bus.m_wdata, bus.m_wr_en, bus.m_bytesel); end
    bus.a_addr = 32'h4000; bus.a_wr_en = 1'b0; bus.a_bytesel = 4'hf;
    tick(); tick();
    n_cmp++; if (dbg_s !== 2'd2 || bus.m_addr !== 32'h3000 || bus.m_bytesel !== 4'h3) begin n_bad++; $display("FAIL b2b_b_held: got %0d %h %h want 2 3000 3", dbg_s, bus.m_addr, bus.m_bytesel); end
    bus.m_compl = 1'b1; bus.m_rdata = 32'h11112222;
    tick();
    bus.m_compl = 1'b0;
    n_cmp++; if (bus.b_compl !== 1'b1 || bus.a_compl !== 1'b0 || bus.b_rdata !== 32'h11112222 || dbg_s !== 2'd0) begin n_bad++; $display("FAIL b2b_b_done: got %b %b %h %0d want 1 0 11112222 0", bus.b_compl, bus.a_compl, bus.b_rdata, dbg_s); end
    bus.b_bytesel = 4'h0; bus.b_wr_en = 1'b0;
    tick();
    n_cmp++; if (dbg_s !== 2'd1 || bus.m_addr !== 32'h4000 || bus.m_bytesel !== 4'hf) begin n_bad++; $display("FAIL b2b_a_next: got %0d %h %h want 1 4000 f", dbg_s, bus.m_addr, bus.m_bytesel); end
    bus.m_compl = 1'b1; bus.m_rdata = 32'h5;
    tick();
    bus.m_compl = 1'b0;
    n_cmp++; if (bus.a_compl !== 1'b1 || bus.a_rdata !== 32'h5) begin n_bad++; $display("FAIL b2b_a_done: got %b %h want 1 5", bus.a_compl, bus.a_rdata); end
    bus.a_bytesel = 4'h0;
    tick();
  endtask

  task automatic test_idle_compl();
    bus.m_compl = 1'b1; bus.m_rdata = 32'hffffffff;
    tick();
    bus.m_compl = 1'b0;
    n_cmp++; if (bus.a_compl !== 1'b0 || bus.b_compl !== 1'b0 || bus.a_rdata !== 32'h5 || dbg_s !== 2'd0) begin n_bad++; $display("FAIL idle_spurious: got %b %b %h %0d want 0 0 5 0", bus.a_compl, bus.b_compl, bus.a_rdata, dbg_s); end
  endtask

  task automatic test_timeout();
    bus_to.a_addr = 32'h10; bus_to.a_bytesel = 4'hf;
    tick();
    bus_to.m_compl = 1'b1; bus_to.m_rdata = 32'h12345678;
    tick();
    bus_to.m_compl = 1'b0;
    n_cmp++; if (bus_to.a_compl !== 1'b1 || bus_to.a_rdata !== 32'h12345678) begin n_bad++; $display("FAIL to_pre_read: got %b %h want 1 12345678", bus_to.a_compl, bus_to.a_rdata); end
    bus_to.a_bytesel = 4'h0;
    tick();
    bus_to.a_bytesel = 4'hf;
    tick();
    n_cmp++; if (dbg_s_to !== 2'd1) begin n_bad++; $display("FAIL to_grant: got %0d want 1", dbg_s_to); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus_to.a_compl !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", bus_to.a_compl); end
    end
    tick();
    n_cmp++; if (bus_to.a_compl !== 1'b1 || bus_to.a_err !== 1'b1 || bus_to.a_rdata !== 32'h0 || dbg_s_to !== 2'd0) begin n_bad++; $display("FAIL to_fire: got %b %b %h %0d want 1 1 0 0", bus_to.a_compl, bus_to.a_err, bus_to.a_rdata, dbg_s_to); end
    bus_to.a_bytesel = 4'h0;
    tick();
    n_cmp++; if (bus_to.a_compl !== 1'b0 || bus_to.a_err !== 1'b0) begin n_bad++; $display("FAIL to_pulse_len: got %b %b want 0 0", bus_to.a_compl, bus_to.a_err); end
    bus_to.m_compl = 1'b1; bus_to.m_rdata = 32'h99;
    tick();
    bus_to.m_compl = 1'b0;
    n_cmp++; if (bus_to.a_compl !== 1'b0 || bus_to.a_rdata !== 32'h0 || dbg_s_to !== 2'd0) begin n_bad++; $display("FAIL to_late_compl: got %b %h %0d want 0 0 0", bus_to.a_compl, bus_to.a_rdata, dbg_s_to); end
  endtask

  task automatic test_timeout_tie();
    bus_to.a_bytesel = 4'hf;
    tick();
    tick(); tick(); tick();
    n_cmp++; if (bus_to.a_compl !== 1'b0 || dbg_s_to !== 2'd1) begin n_bad++; $display("FAIL tie_pre: got %b %0d want 0 1", bus_to.a_compl, dbg_s_to); end
    bus_to.m_compl = 1'b1; bus_to.m_rdata = 32'hcafe0001;
    tick();
    bus_to.m_compl = 1'b0;
    n_cmp++; if (bus_to.a_compl !== 1'b1 || bus_to.a_err !== 1'b0 || bus_to.a_rdata !== 32'hcafe0001) begin n_bad++; $display("FAIL tie_compl_wins: got %b %b %h want 1 0 cafe0001", bus_to.a_compl, bus_to.a_err, bus_to.a_rdata); end
    bus_to.a_bytesel = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bus.b_addr = 32'h7000; bus.b_bytesel = 4'hf;
    tick();
    n_cmp++; if (dbg_s !== 2'd2 || bus.m_bytesel !== 4'hf) begin n_bad++; $display("FAIL rmg_grant_b: got %0d %h want 2 f", dbg_s, bus.m_bytesel); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.m_bytesel !== 4'h0 || dbg_s !== 2'd0) begin n_bad++; $display("FAIL rmg_async: got %h %0d want 0 0", bus.m_bytesel, dbg_s); end
    bus.a_addr = 32'h8000; bus.a_bytesel = 4'hf;
    tick();
    n_cmp++; if (bus.b_compl !== 1'b0 || dbg_s !== 2'd0) begin n_bad++; $display("FAIL rmg_in_reset: got %b %0d want 0 0", bus.b_compl, dbg_s); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (dbg_s !== 2'd1 || bus.m_addr !== 32'h8000 || bus.b_compl !== 1'b0) begin n_bad++; $display("FAIL rmg_tie_a: got %0d %h %b want 1 8000 0", dbg_s, bus.m_addr, bus.b_compl); end
    bus.m_compl = 1'b1; bus.m_rdata = 32'h77;
    tick();
    bus.m_compl = 1'b0;
    n_cmp++; if (bus.a_compl !== 1'b1 || bus.b_compl !== 1'b0 || bus.a_rdata !== 32'h77) begin n_bad++; $display("FAIL rmg_a_done: got %b %b %h want 1 0 77", bus.a_compl, bus.b_compl, bus.a_rdata); end
    bus.a_bytesel = 4'h0;
    tick();
    n_cmp++; if (dbg_s !== 2'd2) begin n_bad++; $display("FAIL rmg_b_resumes: got %0d want 2", dbg_s); end
    bus.m_compl = 1'b1; bus.m_rdata = 32'h88;
    tick();
    bus.m_compl = 1'b0; bus.b_bytesel = 4'h0;
    n_cmp++; if (bus.b_compl !== 1'b1 || bus.b_rdata !== 32'h88) begin n_bad++; $display("FAIL rmg_b_done: got %b %h want 1 88", bus.b_compl, bus.b_rdata); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_idle_compl();
    test_timeout();
    test_timeout_tie();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
